// File: rtl/hc595_monitor.sv
// Snoops the 74HC595 serial pins, rebuilds each latched sel/seg frame and
// keeps a decoded 6-digit image of what the display is showing.
module hc595_monitor #(
  parameter int FRAME_BITS = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stcp,
  input  logic        shcp,
  input  logic        ds,
  input  logic        oe,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_vld,
  output logic        frame_err,
  output logic        sel_err,
  output logic [23:0] digits,
  output logic [5:0]  points,
  output logic        dig_upd,
  output logic        disp_on
);

  localparam logic [3:0] FULL_COUNT = 4'(FRAME_BITS);

  logic stcp_s1, stcp_s2, stcp_s3;
  logic shcp_s1, shcp_s2, shcp_s3;
  logic ds_s1, ds_s2;
  logic oe_s1, oe_s2;
  logic stcp_rise_q, shcp_rise_q, ds_q;

  logic [FRAME_BITS-1:0] shreg, shreg_next;
  logic [3:0]            bitcnt, cnt_next;
  logic [7:0]            seg_next;
  logic                  latch_ok;
  logic [3:0]            code;

  function automatic logic is_onehot(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

  // oe flops reset high so the display reads as off until oe is really seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stcp_s1     <= 1'b0;
      stcp_s2     <= 1'b0;
      stcp_s3     <= 1'b0;
      shcp_s1     <= 1'b0;
      shcp_s2     <= 1'b0;
      shcp_s3     <= 1'b0;
      ds_s1       <= 1'b0;
      ds_s2       <= 1'b0;
      oe_s1       <= 1'b1;
      oe_s2       <= 1'b1;
      stcp_rise_q <= 1'b0;
      shcp_rise_q <= 1'b0;
      ds_q        <= 1'b0;
    end else begin
      stcp_s1     <= stcp;
      stcp_s2     <= stcp_s1;
      stcp_s3     <= stcp_s2;
      shcp_s1     <= shcp;
      shcp_s2     <= shcp_s1;
      shcp_s3     <= shcp_s2;
      ds_s1       <= ds;
      ds_s2       <= ds_s1;
      oe_s1       <= oe;
      oe_s2       <= oe_s1;
      stcp_rise_q <= stcp_s2 & ~stcp_s3;
      shcp_rise_q <= shcp_s2 & ~shcp_s3;
      ds_q        <= ds_s2;
    end
  end

  assign disp_on = ~oe_s2;

  // Shift lands before the latch check so a same-cycle stcp sees the new count.
  always_comb begin
    shreg_next = shreg;
    cnt_next   = bitcnt;
    if (shcp_rise_q) begin
      shreg_next = {ds_q, shreg[FRAME_BITS-1:1]};
      cnt_next   = (bitcnt == 4'd15) ? 4'd15 : bitcnt + 4'd1;
    end
    latch_ok = stcp_rise_q && (cnt_next == FULL_COUNT);
    seg_next = '0;
    for (int j = 0; j < 8; j++) begin
      seg_next[7-j] = shreg_next[6+j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      bitcnt    <= 4'd0;
      sel       <= 6'd0;
      seg       <= 8'hFF;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      shreg     <= shreg_next;
      bitcnt    <= stcp_rise_q ? 4'd0 : cnt_next;
      frame_vld <= latch_ok;
      frame_err <= stcp_rise_q && !latch_ok;
      sel_err   <= latch_ok && !is_onehot(shreg_next[5:0]);
      if (latch_ok) begin
        sel <= shreg_next[5:0];
        seg <= seg_next;
      end
    end
  end

  always_comb begin
    case (seg[6:0])
      7'h40:   code = 4'h0;
      7'h79:   code = 4'h1;
      7'h24:   code = 4'h2;
      7'h30:   code = 4'h3;
      7'h19:   code = 4'h4;
      7'h12:   code = 4'h5;
      7'h02:   code = 4'h6;
      7'h78:   code = 4'h7;
      7'h00:   code = 4'h8;
      7'h10:   code = 4'h9;
      7'h3F:   code = 4'hA;
      7'h7F:   code = 4'hF;
      default: code = 4'hE;
    endcase
  end

  // Runs one cycle behind the latch, working from the registered sel/seg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits  <= 24'hFFFFFF;
      points  <= 6'd0;
      dig_upd <= 1'b0;
    end else begin
      dig_upd <= frame_vld && !sel_err;
      if (frame_vld && !sel_err) begin
        for (int i = 0; i < 6; i++) begin
          if (sel[i]) begin
            digits[4*i +: 4] <= code;
            points[i]        <= ~seg[7];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hc595_monitor.sv
// Drives serial frames into hc595_monitor and checks every cycle against a
// frame-level model of what the display receiver must report.
module tb_hc595_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stcp = 1'b0;
  logic        shcp = 1'b0;
  logic        ds = 1'b0;
  logic        oe = 1'b1;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        frame_vld, frame_err, sel_err, dig_upd, disp_on;
  logic [23:0] digits;
  logic [5:0]  points;

  hc595_monitor #(.FRAME_BITS(14)) dut (
    .clk(clk), .rst_n(rst_n), .stcp(stcp), .shcp(shcp), .ds(ds), .oe(oe),
    .sel(sel), .seg(seg), .frame_vld(frame_vld), .frame_err(frame_err),
    .sel_err(sel_err), .digits(digits), .points(points), .dig_upd(dig_upd),
    .disp_on(disp_on)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          due;
    bit          kind;
    bit          vld, ferr, serr, upd;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic [23:0] digits;
    logic [5:0]  points;
  } ev_t;

  typedef struct {
    int due;
    bit val;
  } oe_ev_t;

  ev_t    ev_q[$];
  oe_ev_t oe_q[$];
  bit     sent_q[$];
  int     sent_cnt = 0;
  logic [23:0] m_digits = 24'hFFFFFF;
  logic [5:0]  m_points = 6'd0;

  logic [5:0]  e_sel = 6'd0;
  logic [7:0]  e_seg = 8'hFF;
  logic [23:0] e_digits = 24'hFFFFFF;
  logic [5:0]  e_points = 6'd0;
  bit          e_disp = 1'b0;

  logic [7:0] seg_table [13] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                 8'h82, 8'hF8, 8'h80, 8'h90, 8'hBF, 8'hFF, 8'hC7};

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] decode(input logic [6:0] p);
    case (p)
      7'h40: return 4'h0;  7'h79: return 4'h1;  7'h24: return 4'h2;
      7'h30: return 4'h3;  7'h19: return 4'h4;  7'h12: return 4'h5;
      7'h02: return 4'h6;  7'h78: return 4'h7;  7'h00: return 4'h8;
      7'h10: return 4'h9;  7'h3F: return 4'hA;  7'h7F: return 4'hF;
      default: return 4'hE;
    endcase
  endfunction

  // Model of one stcp edge: decides the outcome from the bits sent since the last latch.
  task automatic model_latch();
    ev_t a, b;
    a = '{default: '0};
    b = '{default: '0};
    a.due = cyc + 4;
    a.kind = 1'b0;
    b.due = cyc + 5;
    b.kind = 1'b1;
    if (sent_cnt == 14) begin
      for (int i = 0; i < 6; i++) a.sel[i] = sent_q[i];
      for (int j = 0; j < 8; j++) a.seg[7-j] = sent_q[6+j];
      a.vld  = 1'b1;
      a.serr = ($countones(a.sel) != 1);
      if (!a.serr) begin
        for (int i = 0; i < 6; i++) begin
          if (a.sel[i]) begin
            m_digits[4*i +: 4] = decode(a.seg[6:0]);
            m_points[i] = ~a.seg[7];
          end
        end
        b.upd = 1'b1;
      end
    end else begin
      a.ferr = 1'b1;
    end
    b.digits = m_digits;
    b.points = m_points;
    ev_q.push_back(a);
    ev_q.push_back(b);
    sent_q.delete();
    sent_cnt = 0;
  endtask

  task automatic send_bit(input bit b, input bit latch_too);
    @(negedge clk);
    ds = b;
    shcp = 1'b0;
    repeat (2) @(negedge clk);
    shcp = 1'b1;
    sent_q.push_back(b);
    if (sent_q.size() > 14) void'(sent_q.pop_front());
    sent_cnt++;
    if (latch_too) begin
      stcp = 1'b1;
      model_latch();
    end
    repeat (2) @(negedge clk);
    shcp = 1'b0;
    if (latch_too) begin
      @(negedge clk);
      stcp = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic pulse_stcp();
    @(negedge clk);
    stcp = 1'b1;
    model_latch();
    repeat (3) @(negedge clk);
    stcp = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Sends nbits shifts ending with the 14-bit frame image, then latches.
  task automatic apply_stimulus(input logic [5:0] s, input logic [7:0] g,
                                input int nbits, input bit same_cycle);
    bit seq[14];
    for (int i = 0; i < 6; i++) seq[i] = s[i];
    for (int j = 0; j < 8; j++) seq[6+j] = g[7-j];
    if (nbits > 14) begin
      for (int k = 0; k < nbits - 14; k++) send_bit(1'($urandom_range(0, 1)), 1'b0);
      for (int k = 0; k < 14; k++) send_bit(seq[k], same_cycle && (k == 13));
    end else begin
      for (int k = 0; k < nbits; k++) send_bit(seq[k], same_cycle && (k == nbits - 1));
    end
    if (!same_cycle || nbits == 0) pulse_stcp();
  endtask

  task automatic set_oe(input bit v);
    @(negedge clk);
    oe = v;
    if (rst_n) oe_q.push_back('{cyc + 2, ~v});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    shcp = 1'b0;
    stcp = 1'b0;
    ev_q.delete();
    oe_q.delete();
    sent_q.delete();
    sent_cnt = 0;
    m_digits = 24'hFFFFFF;
    m_points = 6'd0;
    e_sel = 6'd0;
    e_seg = 8'hFF;
    e_digits = 24'hFFFFFF;
    e_points = 6'd0;
    e_disp = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    oe_q.push_back('{cyc + 2, ~oe});
  endtask

  always @(negedge clk) begin
    ev_t ev;
    bit p_vld, p_ferr, p_serr, p_upd;
    #1;
    p_vld = 0; p_ferr = 0; p_serr = 0; p_upd = 0;
    while (ev_q.size() > 0 && ev_q[0].due <= cyc) begin
      ev = ev_q.pop_front();
      if (ev.kind == 1'b0) begin
        p_vld = ev.vld; p_ferr = ev.ferr; p_serr = ev.serr;
        if (ev.vld) begin
          e_sel = ev.sel;
          e_seg = ev.seg;
        end
      end else begin
        p_upd = ev.upd;
        e_digits = ev.digits;
        e_points = ev.points;
      end
    end
    while (oe_q.size() > 0 && oe_q[0].due <= cyc) e_disp = oe_q.pop_front().val;
    check_output("sel", 32'(sel), 32'(e_sel));
    check_output("seg", 32'(seg), 32'(e_seg));
    check_output("frame_vld", 32'(frame_vld), 32'(p_vld));
    check_output("frame_err", 32'(frame_err), 32'(p_ferr));
    check_output("sel_err", 32'(sel_err), 32'(p_serr));
    check_output("dig_upd", 32'(dig_upd), 32'(p_upd));
    check_output("digits", 32'(digits), 32'(e_digits));
    check_output("points", 32'(points), 32'(e_points));
    check_output("disp_on", 32'(disp_on), 32'(e_disp));
  end

  initial begin
    logic [5:0] rs;
    logic [7:0] rg;
    int nb;
    $display("[TB] start");
    repeat (2) @(negedge clk);
    check_output("reset_digits_lit", 32'(digits), 32'h00FFFFFF);
    check_output("reset_seg_lit", 32'(seg), 32'h000000FF);
    rst_n = 1'b1;
    oe_q.push_back('{cyc + 2, ~oe});
    repeat (3) @(negedge clk);

    apply_stimulus(6'b000001, 8'hC0, 14, 1'b0);
    repeat (4) @(negedge clk);
    check_output("f1_sel_lit", 32'(sel), 32'h01);
    check_output("f1_seg_lit", 32'(seg), 32'hC0);
    check_output("f1_digit_lit", 32'(digits[3:0]), 32'h0);

    apply_stimulus(6'b100000, 8'hF9, 14, 1'b0);
    apply_stimulus(6'b010000, 8'hA4, 14, 1'b1);
    apply_stimulus(6'b001000, 8'hB0, 14, 1'b0);
    apply_stimulus(6'b000100, 8'h19, 14, 1'b1);
    apply_stimulus(6'b000010, 8'h92, 14, 1'b0);
    apply_stimulus(6'b000001, 8'h82, 14, 1'b0);
    repeat (4) @(negedge clk);
    check_output("123456_digits_lit", 32'(digits), 32'h123456);
    check_output("123456_points_lit", 32'(points), 32'h04);

    apply_stimulus(6'b000001, 8'hF8, 13, 1'b0);
    repeat (4) @(negedge clk);
    check_output("short_seg_lit", 32'(seg), 32'h82);
    apply_stimulus(6'b000001, 8'hF8, 14, 1'b0);
    apply_stimulus(6'b000010, 8'h80, 16, 1'b0);
    repeat (4) @(negedge clk);
    check_output("long_digits_lit", 32'(digits), 32'h123457);

    apply_stimulus(6'b000011, 8'hA4, 14, 1'b0);
    repeat (4) @(negedge clk);
    check_output("selerr_digits_lit", 32'(digits), 32'h123457);

    for (int k = 0; k < 7; k++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    apply_reset();
    repeat (2) @(negedge clk);
    check_output("midreset_digits_lit", 32'(digits), 32'hFFFFFF);
    pulse_stcp();
    apply_stimulus(6'b000100, 8'h92, 14, 1'b0);
    repeat (4) @(negedge clk);
    check_output("postreset_digits_lit", 32'(digits), 32'hFFF5FF);

    set_oe(1'b0);
    repeat (3) @(negedge clk);
    check_output("disp_on_lit", 32'(disp_on), 32'h1);
    set_oe(1'b1);
    repeat (3) @(negedge clk);
    check_output("disp_off_lit", 32'(disp_on), 32'h0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) != 0) rs = 6'(1 << $urandom_range(0, 5));
      else rs = 6'($urandom);
      if ($urandom_range(0, 3) != 0)
        rg = {1'($urandom_range(0, 1)), seg_table[$urandom_range(0, 12)][6:0]};
      else rg = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       nb = 12;
        1:       nb = 13;
        2:       nb = 15;
        3:       nb = 16;
        default: nb = 14;
      endcase
      if ($urandom_range(0, 7) == 0) set_oe(~oe);
      apply_stimulus(rs, rg, nb, ($urandom_range(0, 2) == 0));
    end
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
